lane_mode_ctrl: RTL
===================

Name: lane_mode_ctrl

Overview:
- Sequences safe run-time changes of the link lane mode (single-lane vs. multi-lane) and drives the lane-clock divider's reset and mode inputs.
- On a mode request it quiesces the link, waits for the transmit datapath to drain, and holds the divider in reset while its mode input changes.
- It then waits a settle period before re-enabling the link.
- It sits between the link management logic (requester) and the clock divider / TX datapath.

Parameters:
- INIT_SINGLE_LANE, 0, lane mode applied after reset (1 = single lane, divider /8; 0 = multi-lane, divider /2).
- DRAIN_CYCLES, 4, consecutive cycles tx_idle must be high before the divider is reset.
- RST_CYCLES, 2, cycles div_rst_n is held low (≥2, because the divider samples its mode synchronously while in reset).
- SETTLE_CYCLES, 16, cycles after divider reset release before the link is re-enabled.
- IDLE_TIMEOUT, 256, maximum cycles spent waiting for drain before forcing the switch.

Ports:
- clk_in  in  1  system clock (same clock as the divider input).
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  mode change request valid.
- req_single_lane  in  1  requested mode, qualified by req_valid.
- req_ready  out  1  controller can accept a request.
- tx_idle  in  1  TX datapath has no frame in flight.
- div_rst_n  out  1  active-low reset to the clock divider.
- div_single_lane  out  1  mode select to the clock divider.
- link_en  out  1  enables the TX/RX datapath.
- busy  out  1  a switch or post-reset sequence is in progress.
- switch_done  out  1  one-cycle pulse when a requested switch completes.
- err_timeout  out  1  sticky flag: a drain wait timed out.

Behaviour:
- All outputs are registered. One counter, sized to $clog2(max parameter)+1, is reused across states; a separate timeout counter runs in WAIT_IDLE.
- Reset (async assert, sync to clk_in on release) sets:
  - state = DIV_RST, div_rst_n = 0, div_single_lane = INIT_SINGLE_LANE
  - link_en = 0, busy = 1, req_ready = 0, switch_done = 0, err_timeout = 0
- States:
  - RUN: req_ready = 1, link_en = 1, busy = 0. A request is accepted on a cycle with req_valid && req_ready.
    - If req_single_lane == div_single_lane: stay in RUN; switch_done pulses on the next cycle; link_en is unaffected.
    - Otherwise: latch the new mode. Next cycle: state = WAIT_IDLE, link_en = 0, req_ready = 0, busy = 1.
  - WAIT_IDLE: the drain counter increments each cycle tx_idle = 1 and clears to 0 on any cycle tx_idle = 0.
    - When the drain counter reaches DRAIN_CYCLES, go to DIV_RST.
    - The timeout counter counts every cycle in WAIT_IDLE. On reaching IDLE_TIMEOUT, go to DIV_RST and set err_timeout = 1.
    - If both conditions hit on the same cycle: go to DIV_RST and do not set err_timeout.
  - DIV_RST: on entry, div_rst_n = 0 and div_single_lane = latched mode, changing on the same edge. Held for exactly RST_CYCLES cycles, then go to SETTLE.
  - SETTLE: div_rst_n = 1, div_single_lane unchanged. Held for exactly SETTLE_CYCLES cycles, then go to RUN.
    - link_en = 1 and req_ready = 1 on the first RUN cycle.
    - switch_done = 1 for that single cycle only when entered from a request; no pulse after power-up reset.
- Latency: with tx_idle held high and the request accepted at cycle 0:
  - WAIT_IDLE cycles 1..DRAIN_CYCLES
  - DIV_RST for the next RST_CYCLES cycles
  - SETTLE for the next SETTLE_CYCLES cycles
  - RUN, with switch_done, at cycle 1+DRAIN+RST+SETTLE (= 23 with defaults).
- req_valid while req_ready = 0 is ignored; the requester must hold it. Changes to req_single_lane while not accepted have no effect.
- err_timeout is cleared only by rst_n.
- rst_n asserted mid-sequence aborts immediately to the reset values above. div_single_lane returns to INIT_SINGLE_LANE and the latched mode is discarded.
- After reset release: DIV_RST (RST_CYCLES) → SETTLE (SETTLE_CYCLES) → RUN, with first RUN at cycle RST+SETTLE (= 18).

Test Plan:
- Reset release with defaults → div_rst_n = 0 for cycles 0..1, link_en rises at cycle 18, switch_done stays 0, div_single_lane = 0.
- In RUN, request single lane (1) with tx_idle = 1 → link_en = 0 at cycle 1, div_rst_n low cycles 5..6 with div_single_lane = 1 from cycle 5, link_en = 1 and switch_done pulse at cycle 23.
- Request the mode equal to the current one → req_ready stays 1, link_en stays 1, switch_done pulses once at cycle 1.
- tx_idle pattern 1,1,1,0,1,1,1,1 during WAIT_IDLE → DIV_RST entered only after the final 4 consecutive highs (cycle 9); err_timeout = 0.
- tx_idle held 0 → DIV_RST entered after 256 WAIT_IDLE cycles, err_timeout = 1 and held through the next successful switch.
- Assert rst_n during SETTLE of a 0→1 switch → all outputs return to reset values asynchronously, div_single_lane = 0, no switch_done pulse.

Source files
------------

// File: rtl/lane_mode_ctrl.sv
// Lane-mode switch sequencer: quiesces the link, drains TX, holds the lane-clock
// divider in reset while its mode input changes, then settles and re-enables the link.
module lane_mode_ctrl #(
    parameter bit          INIT_SINGLE_LANE = 1'b0,
    parameter int unsigned DRAIN_CYCLES     = 4,
    parameter int unsigned RST_CYCLES       = 2,
    parameter int unsigned SETTLE_CYCLES    = 16,
    parameter int unsigned IDLE_TIMEOUT     = 256
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_single_lane,
    output logic req_ready,
    input  logic tx_idle,
    output logic div_rst_n,
    output logic div_single_lane,
    output logic link_en,
    output logic busy,
    output logic switch_done,
    output logic err_timeout
);

    localparam int unsigned MAX_AB  = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int unsigned TO_W    = $clog2(IDLE_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        RUN,
        WAIT_IDLE,
        DIV_RST,
        SETTLE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              mode_q, mode_d;
    logic              from_req_q, from_req_d;

    logic              req_ready_q, req_ready_d;
    logic              div_rst_n_q, div_rst_n_d;
    logic              div_sl_q, div_sl_d;
    logic              link_en_q, link_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              drain_hit;
    logic              to_hit;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DIV_RST;
            cnt_q       <= '0;
            to_cnt_q    <= '0;
            mode_q      <= INIT_SINGLE_LANE;
            from_req_q  <= 1'b0;
            req_ready_q <= 1'b0;
            div_rst_n_q <= 1'b0;
            div_sl_q    <= INIT_SINGLE_LANE;
            link_en_q   <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_cnt_q    <= to_cnt_d;
            mode_q      <= mode_d;
            from_req_q  <= from_req_d;
            req_ready_q <= req_ready_d;
            div_rst_n_q <= div_rst_n_d;
            div_sl_q    <= div_sl_d;
            link_en_q   <= link_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        to_cnt_d   = to_cnt_q;
        mode_d     = mode_q;
        from_req_d = from_req_q;
        err_d      = err_q;
        done_d     = 1'b0;
        drain_hit  = 1'b0;
        to_hit     = 1'b0;

        unique case (state_q)
            RUN: begin
                if (req_valid && req_ready_q) begin
                    if (req_single_lane == div_sl_q) begin
                        done_d = 1'b1;
                    end else begin
                        mode_d     = req_single_lane;
                        from_req_d = 1'b1;
                        state_d    = WAIT_IDLE;
                        cnt_d      = '0;
                        to_cnt_d   = '0;
                    end
                end
            end
            WAIT_IDLE: begin
                // A drain completing on the timeout cycle wins, so no error is flagged.
                drain_hit = tx_idle && (cnt_q == CNT_W'(DRAIN_CYCLES - 1));
                to_hit    = (to_cnt_q == TO_W'(IDLE_TIMEOUT - 1));
                cnt_d     = tx_idle ? (cnt_q + CNT_W'(1)) : '0;
                to_cnt_d  = to_cnt_q + TO_W'(1);
                if (drain_hit || to_hit) begin
                    state_d = DIV_RST;
                    cnt_d   = '0;
                    if (!drain_hit) begin
                        err_d = 1'b1;
                    end
                end
            end
            DIV_RST: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    done_d     = from_req_q;
                    from_req_d = 1'b0;
                end
            end
            default: begin
                state_d = DIV_RST;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered copies of the next state's decode.
        req_ready_d = (state_d == RUN);
        link_en_d   = (state_d == RUN);
        busy_d      = (state_d != RUN);
        div_rst_n_d = (state_d != DIV_RST);
        div_sl_d    = (state_d == DIV_RST) ? mode_q : div_sl_q;
    end

    assign req_ready       = req_ready_q;
    assign div_rst_n       = div_rst_n_q;
    assign div_single_lane = div_sl_q;
    assign link_en         = link_en_q;
    assign busy            = busy_q;
    assign switch_done     = done_q;
    assign err_timeout     = err_q;

endmodule
